// File: rtl/vending_dispense_ctrl.sv
// Output-side sequencer for the vending machine: queues sale events and plays each
// one out as timed drink-motor and change-hopper pulses, one event at a time.
module vending_dispense_ctrl #(
   parameter int MOTOR_CYC = 8,
   parameter int COIN_CYC  = 4,
   parameter int GAP_CYC   = 2,
   parameter int QDEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sell_i,
   input  logic [1:0] change_i,
   output logic       motor_o,
   output logic       hopper_o,
   output logic       coin_block_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       drop_err_o
);

   localparam int AW      = $clog2(QDEPTH);
   localparam int CW      = AW + 1;
   localparam int MAX_AB  = (MOTOR_CYC > COIN_CYC) ? MOTOR_CYC : COIN_CYC;
   localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
   localparam int TW      = $clog2(MAX_CYC) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MOTOR  = 3'd1;
   localparam logic [2:0] S_HOPPER = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]    fifo_mem [QDEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nx;
   logic [2:0]    state, state_nx;
   logic [TW-1:0] tmr, tmr_nx;
   logic [1:0]    coin_cnt_r, coin_cnt_nx;
   logic [2:0]    head;
   logic          push, pop, accept, drop;

   assign head   = fifo_mem[rd_ptr];
   assign push   = sell_i | (change_i != 2'd0);
   assign pop    = (state == S_IDLE) && (count != '0);
   // A full queue still takes a push when its head leaves in the same cycle.
   assign accept = push && ((count != CW'(QDEPTH)) || pop);
   assign drop   = push && !accept;
   assign count_nx = count + CW'(accept) - CW'(pop);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_nx    = state;
      tmr_nx      = tmr;
      coin_cnt_nx = coin_cnt_r;
      case (state)
         S_IDLE: begin
            if (pop) begin
               coin_cnt_nx = head[1:0];
               if (head[2]) begin
                  state_nx = S_MOTOR;
                  tmr_nx   = TW'(MOTOR_CYC - 1);
               end else begin
                  state_nx = S_HOPPER;
                  tmr_nx   = TW'(COIN_CYC - 1);
               end
            end
         end
         S_MOTOR: begin
            if (tmr == '0) begin
               state_nx = S_GAP;
               tmr_nx   = TW'(GAP_CYC - 1);
            end else begin
               tmr_nx = tmr - TW'(1);
            end
         end
         S_HOPPER: begin
            if (tmr == '0) begin
               coin_cnt_nx = coin_cnt_r - 2'd1;
               state_nx    = S_GAP;
               tmr_nx      = TW'(GAP_CYC - 1);
            end else begin
               tmr_nx = tmr - TW'(1);
            end
         end
         S_GAP: begin
            if (tmr == '0) begin
               if (coin_cnt_r != 2'd0) begin
                  state_nx = S_HOPPER;
                  tmr_nx   = TW'(COIN_CYC - 1);
               end else begin
                  state_nx = S_DONE;
                  tmr_nx   = '0;
               end
            end else begin
               tmr_nx = tmr - TW'(1);
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            tmr_nx   = '0;
         end
         default: begin
            state_nx = S_IDLE;
            tmr_nx   = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         state        <= S_IDLE;
         tmr          <= '0;
         coin_cnt_r   <= '0;
         motor_o      <= 1'b0;
         hopper_o     <= 1'b0;
         coin_block_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         drop_err_o   <= 1'b0;
      end else begin
         rd_ptr       <= rd_ptr + AW'(pop);
         wr_ptr       <= wr_ptr + AW'(accept);
         count        <= count_nx;
         state        <= state_nx;
         tmr          <= tmr_nx;
         coin_cnt_r   <= coin_cnt_nx;
         // Drives are decoded from the next state so they line up with the state they belong to.
         motor_o      <= (state_nx == S_MOTOR);
         hopper_o     <= (state_nx == S_HOPPER);
         done_o       <= (state_nx == S_DONE);
         drop_err_o   <= drop;
         coin_block_o <= (count_nx >= CW'(QDEPTH - 1));
         busy_o       <= (state_nx != S_IDLE) || (count_nx != '0);
      end
   end

   // NOTE: queue storage is deliberately not reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (accept) fifo_mem[wr_ptr] <= {sell_i, change_i};
   end

endmodule

// File: tb/tb_vending_dispense_ctrl.sv
// Self-checking bench for vending_dispense_ctrl: an event-level reference model is
// compared against the DUT every cycle, plus directed scenarios with literal timings.
module tb_vending_dispense_ctrl;

   localparam int MOTOR_CYC = 8;
   localparam int COIN_CYC  = 4;
   localparam int GAP_CYC   = 2;
   localparam int QDEPTH    = 4;
   localparam int NREC      = 128;

   logic       clk;
   logic       rst;
   logic       sell_i;
   logic [1:0] change_i;
   logic       motor_o, hopper_o, coin_block_o, busy_o, done_o, drop_err_o;

   vending_dispense_ctrl #(
      .MOTOR_CYC(MOTOR_CYC), .COIN_CYC(COIN_CYC), .GAP_CYC(GAP_CYC), .QDEPTH(QDEPTH)
   ) dut (
      .clk(clk), .rst(rst), .sell_i(sell_i), .change_i(change_i),
      .motor_o(motor_o), .hopper_o(hopper_o), .coin_block_o(coin_block_o),
      .busy_o(busy_o), .done_o(done_o), .drop_err_o(drop_err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pending events plus a per-cycle activity plan for the current event.
   typedef enum int {P_IDLE, P_MOTOR, P_HOP, P_GAP, P_DONE} phase_t;
   logic [2:0] mq[$];
   phase_t     plan[$];
   phase_t     cur = P_IDLE;
   bit         e_drop = 1'b0;
   bit         model_valid = 1'b0;

   task automatic model_step();
      bit pop, push, drop;
      logic [2:0] e;
      if (rst) begin
         mq.delete();
         plan.delete();
         cur = P_IDLE;
         e_drop = 1'b0;
         model_valid = 1'b1;
         return;
      end
      if (!model_valid) return;
      pop  = (cur == P_IDLE) && (mq.size() > 0);
      push = sell_i || (change_i != 2'd0);
      drop = push && (mq.size() == QDEPTH) && !pop;
      if (pop) begin
         e = mq.pop_front();
         if (e[2]) begin
            repeat (MOTOR_CYC) plan.push_back(P_MOTOR);
            repeat (GAP_CYC) plan.push_back(P_GAP);
         end
         for (int c = 0; c < int'(e[1:0]); c++) begin
            repeat (COIN_CYC) plan.push_back(P_HOP);
            repeat (GAP_CYC) plan.push_back(P_GAP);
         end
         plan.push_back(P_DONE);
      end
      if (push && !drop) mq.push_back({sell_i, change_i});
      e_drop = drop;
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = P_IDLE;
   endtask

   // Compare on the falling edge, then advance the model across the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            check("motor_o", int'(motor_o), int'(cur == P_MOTOR));
            check("hopper_o", int'(hopper_o), int'(cur == P_HOP));
            check("done_o", int'(done_o), int'(cur == P_DONE));
            check("drop_err_o", int'(drop_err_o), int'(e_drop));
            check("coin_block_o", int'(coin_block_o), int'(mq.size() >= QDEPTH - 1));
            check("busy_o", int'(busy_o), int'((cur != P_IDLE) || (mq.size() != 0)));
         end
         model_step();
      end
   end

   // Directed schedule and per-cycle recording.
   bit         s_sell [NREC];
   logic [1:0] s_chg  [NREC];
   bit         s_rst  [NREC];
   bit r_motor [NREC], r_hop [NREC], r_busy [NREC], r_blk [NREC], r_drop [NREC];
   int m_first, m_cnt, h_first, h_cnt, d_first, d_last, d_cnt, drop_cnt, blk_first, any_cnt;

   task automatic clear_sched();
      for (int k = 0; k < NREC; k++) begin
         s_sell[k] = 1'b0;
         s_chg[k]  = 2'd0;
         s_rst[k]  = 1'b0;
      end
   endtask

   task automatic run_sched(input int n);
      m_first = -1; m_cnt = 0; h_first = -1; h_cnt = 0;
      d_first = -1; d_last = -1; d_cnt = 0; drop_cnt = 0; blk_first = -1; any_cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         sell_i   = s_sell[k];
         change_i = s_chg[k];
         rst      = s_rst[k];
         @(negedge clk);
         r_motor[k] = motor_o;
         r_hop[k]   = hopper_o;
         r_busy[k]  = busy_o;
         r_blk[k]   = coin_block_o;
         r_drop[k]  = drop_err_o;
         if (motor_o) begin m_cnt++; if (m_first < 0) m_first = k; end
         if (hopper_o) begin h_cnt++; if (h_first < 0) h_first = k; end
         if (done_o) begin d_cnt++; d_last = k; if (d_first < 0) d_first = k; end
         if (drop_err_o) drop_cnt++;
         if (coin_block_o && blk_first < 0) blk_first = k;
         if (motor_o | hopper_o | done_o | drop_err_o | coin_block_o | busy_o) any_cnt++;
      end
      clear_sched();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         sell_i = 1'b0;
         change_i = 2'd0;
         rst = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int r;
      rst = 1'b1;
      sell_i = 1'b0;
      change_i = 2'd0;
      clear_sched();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Reset then idle
      run_sched(20);
      check("idle_any_output", any_cnt, 0);

      // Single sale {sell=1, change=1}
      s_sell[0] = 1'b1; s_chg[0] = 2'd1;
      run_sched(24);
      check("sale_motor_first", m_first, 2);
      check("sale_motor_cnt", m_cnt, 8);
      check("sale_motor_at9", int'(r_motor[9]), 1);
      check("sale_motor_at10", int'(r_motor[10]), 0);
      check("sale_hop_first", h_first, 12);
      check("sale_hop_cnt", h_cnt, 4);
      check("sale_done_cycle", d_first, 18);
      check("sale_done_cnt", d_cnt, 1);
      check("sale_busy_at18", int'(r_busy[18]), 1);
      check("sale_busy_at19", int'(r_busy[19]), 0);
      idle(4);

      // Change-only event, 3 coins
      s_chg[0] = 2'd3;
      run_sched(24);
      check("chg_motor_cnt", m_cnt, 0);
      check("chg_hop_first", h_first, 2);
      check("chg_hop_cnt", h_cnt, 12);
      check("chg_hop_at5", int'(r_hop[5]), 1);
      check("chg_hop_at6", int'(r_hop[6]), 0);
      check("chg_hop_at8", int'(r_hop[8]), 1);
      check("chg_hop_at17", int'(r_hop[17]), 1);
      check("chg_done_cycle", d_first, 20);
      idle(4);

      // Overflow: six sells while the first event is in MOTOR
      s_sell[0] = 1'b1;
      for (int k = 3; k <= 8; k++) s_sell[k] = 1'b1;
      run_sched(70);
      check("ovf_block_first", blk_first, 6);
      check("ovf_drop_cnt", drop_cnt, 2);
      check("ovf_drop_at8", int'(r_drop[8]), 1);
      check("ovf_drop_at9", int'(r_drop[9]), 1);
      check("ovf_done_cnt", d_cnt, 5);
      check("ovf_done_last", d_last, 60);
      idle(4);

      // Full queue plus a push in the pop cycle
      s_sell[0] = 1'b1; s_chg[0] = 2'd1;
      s_chg[3] = 2'd1;
      s_chg[4] = 2'd2;
      s_chg[5] = 2'd3;
      s_sell[6] = 1'b1;
      s_sell[19] = 1'b1; s_chg[19] = 2'd2;
      run_sched(110);
      check("full_block_at7", int'(r_blk[7]), 1);
      check("full_block_at20", int'(r_blk[20]), 1);
      check("full_drop_cnt", drop_cnt, 0);
      check("full_done_cnt", d_cnt, 6);
      check("full_done_last", d_last, 96);
      idle(4);

      // Reset mid-operation with two events queued
      s_sell[0] = 1'b1; s_sell[1] = 1'b1; s_sell[2] = 1'b1;
      s_rst[5] = 1'b1;
      run_sched(40);
      check("rst_motor_at5", int'(r_motor[5]), 1);
      check("rst_motor_at6", int'(r_motor[6]), 0);
      check("rst_busy_at6", int'(r_busy[6]), 0);
      check("rst_done_cnt", d_cnt, 0);

      // Fresh sale after reset
      s_sell[0] = 1'b1;
      run_sched(16);
      check("post_rst_motor_first", m_first, 2);
      check("post_rst_done_cycle", d_first, 12);
      idle(4);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 800; k++) begin
         @(posedge clk);
         #1;
         r = int'($urandom_range(0, 99));
         rst = (r == 0);
         if (r < 25) begin
            sell_i   = 1'($urandom_range(0, 1));
            change_i = 2'($urandom_range(0, 3));
         end else begin
            sell_i   = 1'b0;
            change_i = 2'd0;
         end
      end
      idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
